// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with locked bursts capped by a starvation limit.
// State | meaning:  IDLE | plain round-robin  ;  OWN | owner_q holds a locked burst
module bus_arbiter #(
  parameter  int N        = 8,
  parameter  int NSRC     = 6,
  parameter  int MAX_LOCK = 4,
  localparam int IDW      = $clog2(NSRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC-1:0]   lock,
  input  logic [NSRC*N-1:0] src_data,
  output logic [N-1:0]      bus_out,
  output logic              bus_valid,
  output logic [NSRC-1:0]   grant,
  output logic [IDW-1:0]    grant_id,
  output logic              locked
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]  LOCK_MAX = CW'(MAX_LOCK);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NSRC - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [N-1:0]      bus_q, bus_d;
  logic              valid_q, valid_d;
  logic [NSRC-1:0]   grant_q, grant_d;
  logic [IDW-1:0]    gid_q, gid_d;

  logic [NSRC-1:0]   owner_oh, cand, rot;
  logic              starve, owner_keeps, win;
  logic [IDW-1:0]    win_id;
  int                idx;

  always_comb begin
    owner_oh    = NSRC'(1) << owner_q;
    starve      = (state_q == OWN) && (lock_cnt_q == LOCK_MAX) && (|(req & ~owner_oh));
    owner_keeps = (state_q == OWN) && req[owner_q] && lock[owner_q] && !starve;
    cand        = starve ? (req & ~owner_oh) : req;
    // rotate so that bit 0 is the source at ptr; first set bit is the RR winner
    rot         = NSRC'({cand, cand} >> ptr_q);
    win         = 1'b0;
    win_id      = '0;
    idx         = 0;
    for (int k = 0; k < NSRC; k++) begin
      if (!win && rot[k]) begin
        win = 1'b1;
        idx = int'(ptr_q) + k;
        if (idx >= NSRC) idx = idx - NSRC;
        win_id = IDW'(idx);
      end
    end
    if (owner_keeps) begin
      win    = 1'b1;
      win_id = owner_q;
    end
  end

  always_comb begin
    state_d    = IDLE;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    lock_cnt_d = '0;
    bus_d      = '0;
    valid_d    = 1'b0;
    grant_d    = '0;
    gid_d      = '0;
    if (win) begin
      grant_d = NSRC'(1) << win_id;
      gid_d   = win_id;
      bus_d   = N'(src_data >> (int'(win_id) * N));
      valid_d = 1'b1;
      ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      if (lock[win_id]) begin
        state_d = OWN;
        owner_d = win_id;
        if (owner_keeps)
          lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
        else
          lock_cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      bus_q      <= '0;
      valid_q    <= 1'b0;
      grant_q    <= '0;
      gid_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      grant_q    <= grant_d;
      gid_q      <= gid_d;
    end
  end

  assign bus_out   = bus_q;
  assign bus_valid = valid_q;
  assign grant     = grant_q;
  assign grant_id  = gid_q;
  assign locked    = (state_q == OWN);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised successor to the datapath bus source select. It arbitrates NSRC requesting sources onto one N-bit shared bus using round-robin priority, with optional locked bursts bounded by a starvation limit. The winning source's data is registered onto the bus each cycle, and a one-hot grant acknowledges the capture. It sits between the register file, ALU and memory outputs and every bus consumer, and replaces the static decoded bus select.

## Interface
Parameters:
- N, 8, bus data width (≥1)
- NSRC, 6, number of sources (≥2)
- MAX_LOCK, 4, max consecutive locked grants to one owner while others wait (≥1)
- IDW, $clog2(NSRC), width of grant_id (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  synchronous, active-low reset
- req  input  NSRC  per-source request; bit i = source i
- lock  input  NSRC  per-source burst lock; meaningful only with req[i]
- src_data  input  NSRC*N  flattened source data; source i at [i*N +: N]
- bus_out  output  N  registered bus value
- bus_valid  output  1  bus_out holds a granted source's data this cycle
- grant  output  NSRC  registered one-hot; bit i = source i was captured at the last edge
- grant_id  output  IDW  index of the granted source; 0 when bus_valid=0
- locked  output  1  arbiter is in OWN state

## Operation
- State: FSM {IDLE, OWN}, owner index, round-robin pointer ptr (IDW bits), and lock_cnt (counts to MAX_LOCK, saturating).
- Each edge, pick winner w from eligible requesters:
  - OWN with req[owner]=1: owner wins, unless it is excluded by the starvation rule.
  - Otherwise: the first set req bit searching ptr, ptr+1, … NSRC-1, 0, … ptr-1.
- On a win: grant <= onehot(w), grant_id <= w, bus_out <= src_data[w], bus_valid <= 1, ptr <= (w==NSRC-1) ? 0 : w+1.
- No eligible requester: grant <= 0, grant_id <= 0, bus_out <= '0, bus_valid <= 0, ptr unchanged.
- FSM transitions:
  - IDLE -> OWN when w has lock[w]=1. Owner <= w, lock_cnt <= 1.
  - OWN -> OWN when the owner wins again with lock still set. lock_cnt <= min(lock_cnt+1, MAX_LOCK).
  - OWN -> IDLE when the owner's req or lock is low. Re-arbitration happens in the same cycle; the round-robin winner may itself enter OWN.
- Starvation rule: if lock_cnt==MAX_LOCK and any other req bit is set, the owner is ineligible for that edge. The round-robin winner takes the bus, and the FSM leaves OWN (or re-enters OWN for the new winner if it has lock set). If no other requester exists, the owner keeps winning and lock_cnt stays at MAX_LOCK.
- lock[i] without req[i] has no effect.
- Sources treat grant[i] as acknowledgement. To transfer again, a source keeps req high; to stop, it drops req.
- Width rules: src_data slices are fixed at N bits with no sign extension. ptr wraps modulo NSRC, including non-power-of-two NSRC.

## Timing
- Latency: inputs sampled at edge k produce bus_out, grant and bus_valid after edge k, visible in cycle k+1. Latency is exactly one cycle.
- Throughput: one transfer per cycle, with back-to-back grants to different sources and no bubble.
- Reset (rst_n=0 at an edge):
  - bus_out=0, bus_valid=0, grant=0, grant_id=0, locked=0.
  - ptr=0, lock_cnt=0, FSM=IDLE.
  - Reset overrides any in-progress burst.
  - First arbitration happens at the first edge with rst_n=1.
- Simultaneous events:
  - Owner drops lock while others request: others compete by round-robin that same edge.
  - Starvation release and owner lock drop in the same cycle: identical result (owner excluded or not competing first).
- All outputs are driven by flops only; no combinational input-to-output path.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=all ones -> all outputs 0 and locked=0; the first edge after release grants source 0 (grant=000001, bus_out=src_data[0]).
- Single requester: req=000100, src_data[2]=8'hA5 -> next cycle bus_valid=1, grant_id=2, bus_out=A5; drop req -> following cycle bus_valid=0, bus_out=0.
- Round-robin and wrap: ptr=0, req=100011 held for 4 cycles -> grant_id sequence 0,1,5,0.
- Locked burst with starvation limit (MAX_LOCK=4): req[1]&lock[1] held, req[3] raised at cycle 2 -> grant_id 1,1,1,1,3, with locked=1 during the owner's four grants; source 1 then wins again, re-entering OWN with lock_cnt=1.
- Lock release: owner 2 locked, drop lock[2] with req[2]=1 and req[4]=1, ptr=3 -> next grant_id=4, locked=0.
- Reset mid-burst: assert rst_n=0 during OWN with lock_cnt=3 -> next cycle all outputs 0 and ptr=0; after release, source 0 wins if requesting.
